// File: rtl/picorv32_freeahb_bridge.sv
// Bridges the PicoRV32 native memory port onto the FreeAHB master user interface.
// Define PICORV32_FREEAHB_TIMEOUT_EN to build in the bus watchdog (bus_timeout, ERR_RDATA).
module picorv32_freeahb_bridge #(
    parameter bit          BIG_ENDIAN_AHB = 1'b1,
    parameter bit          MERGE_STROBES  = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [31:0] freeahb_wdata,
    output logic        freeahb_valid,
    output logic [31:0] freeahb_addr,
    output logic [2:0]  freeahb_size,
    output logic        freeahb_write,
    output logic        freeahb_read,
    output logic [31:0] freeahb_min_len,
    output logic        freeahb_cont,
    output logic [3:0]  freeahb_prot,
    output logic        freeahb_lock,
    input  logic        freeahb_next,
    input  logic [31:0] freeahb_rdata,
    input  logic [31:0] freeahb_result_addr,
    input  logic        freeahb_ready,
    output logic        bus_timeout
);
    // Handshake: a CPU request holds mem_valid until mem_ready pulses; an AHB phase
    // (read/write address, or valid data) is held until freeahb_next accepts it.
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_PLAN, WR_ADDR, WR_DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [3:0]  mask_q, mask_d;
    logic        drop_q, drop_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic [3:0]  prot_q, prot_d;
    logic        bus_timeout_q, bus_timeout_d;
    logic [3:0]  wstrb_sh;
    logic        unused_ok;

    assign wstrb_sh = mem_wstrb >> ptr_q[1:0];

    // Moves the masked bytes of a little-endian word onto the AHB lanes; with a full
    // mask this is also the lane-to-byte mapping for read data.
    function automatic logic [31:0] to_lanes(input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] lanes;
        lanes = '0;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                if (BIG_ENDIAN_AHB) lanes[(3-k)*8 +: 8] = data[k*8 +: 8];
                else                lanes[k*8 +: 8]     = data[k*8 +: 8];
            end
        end
        return lanes;
    endfunction

`ifdef PICORV32_FREEAHB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy;
    assign busy      = state_q inside {RD_ADDR, RD_DATA, WR_ADDR, WR_DATA};
    assign unused_ok = ^{freeahb_result_addr, mem_addr[1:0]};
`else
    assign unused_ok = ^{freeahb_result_addr, mem_addr[1:0], ERR_RDATA, TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        mask_d        = mask_q;
        drop_d        = drop_q;
        mem_ready_d   = 1'b0;
        mem_rdata_d   = mem_rdata_q;
        wdata_d       = wdata_q;
        valid_d       = valid_q;
        addr_d        = addr_q;
        size_d        = size_q;
        write_d       = write_q;
        read_d        = read_q;
        prot_d        = prot_q;
        bus_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid && !mem_ready_q) begin
                    prot_d = {3'b000, ~mem_instr};
                    drop_d = 1'b0;
                    if (mem_wstrb == 4'b0000) begin
                        addr_d  = {mem_addr[31:2], 2'b00};
                        size_d  = 3'b010;
                        read_d  = 1'b1;
                        state_d = RD_ADDR;
                    end else begin
                        ptr_d   = 3'd0;
                        state_d = WR_PLAN;
                    end
                end
            end
            RD_ADDR: begin
                // An accepted address commits the bus transfer even if the CPU has gone.
                if (freeahb_next) begin
                    read_d  = 1'b0;
                    drop_d  = !mem_valid;
                    state_d = RD_DATA;
                end else if (!mem_valid) begin
                    read_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (!mem_valid) drop_d = 1'b1;
                if (freeahb_ready) begin
                    mem_rdata_d = to_lanes(freeahb_rdata, 4'hF);
                    state_d     = DONE;
                end
            end
            WR_PLAN: begin
                if (!mem_valid) drop_d = 1'b1;
                if (ptr_q[2] || drop_q || !mem_valid) begin
                    state_d = DONE;
                end else if (MERGE_STROBES && ptr_q == 3'd0 && mem_wstrb == 4'hF) begin
                    mask_d = 4'hF;
                    size_d = 3'b010;
                    ptr_d  = ptr_q + 3'd4;
                end else if (MERGE_STROBES && !ptr_q[0] && wstrb_sh[1:0] == 2'b11) begin
                    mask_d = 4'b0011 << ptr_q[1:0];
                    size_d = 3'b001;
                    ptr_d  = ptr_q + 3'd2;
                end else if (wstrb_sh[0]) begin
                    mask_d = 4'b0001 << ptr_q[1:0];
                    size_d = 3'b000;
                    ptr_d  = ptr_q + 3'd1;
                end else begin
                    ptr_d  = ptr_q + 3'd1;
                end
                if (!ptr_q[2] && !drop_q && mem_valid && ptr_d != ptr_q + 3'd1 || wstrb_sh[0] && !ptr_q[2] && !drop_q && mem_valid) begin
                    addr_d  = {mem_addr[31:2], ptr_q[1:0]};
                    write_d = 1'b1;
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (freeahb_next) begin
                    wdata_d = to_lanes(mem_wdata, mask_q);
                    valid_d = 1'b1;
                    drop_d  = drop_q || !mem_valid;
                    state_d = WR_DATA;
                end else if (!mem_valid) begin
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (!mem_valid) drop_d = 1'b1;
                if (freeahb_next) begin
                    write_d = 1'b0;
                    valid_d = 1'b0;
                    state_d = WR_PLAN;
                end
            end
            DONE: begin
                mem_ready_d = !drop_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef PICORV32_FREEAHB_TIMEOUT_EN
        if (busy && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            read_d        = 1'b0;
            write_d       = 1'b0;
            valid_d       = 1'b0;
            bus_timeout_d = 1'b1;
            state_d       = DONE;
            if (state_q == RD_ADDR || state_q == RD_DATA) mem_rdata_d = ERR_RDATA;
        end
        cnt_d = (state_d != state_q || !busy) ? '0 : cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            mask_q        <= '0;
            drop_q        <= 1'b0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
            wdata_q       <= '0;
            valid_q       <= 1'b0;
            addr_q        <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            prot_q        <= '0;
            bus_timeout_q <= 1'b0;
`ifdef PICORV32_FREEAHB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            mask_q        <= mask_d;
            drop_q        <= drop_d;
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
            wdata_q       <= wdata_d;
            valid_q       <= valid_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            write_q       <= write_d;
            read_q        <= read_d;
            prot_q        <= prot_d;
            bus_timeout_q <= bus_timeout_d;
`ifdef PICORV32_FREEAHB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign mem_ready       = mem_ready_q;
    assign mem_rdata       = mem_rdata_q;
    assign freeahb_wdata   = wdata_q;
    assign freeahb_valid   = valid_q;
    assign freeahb_addr    = addr_q;
    assign freeahb_size    = size_q;
    assign freeahb_write   = write_q;
    assign freeahb_read    = read_q;
    assign freeahb_min_len = 32'd0;
    assign freeahb_cont    = 1'b0;
    assign freeahb_prot    = prot_q;
    assign freeahb_lock    = 1'b0;
    assign bus_timeout     = bus_timeout_q;
endmodule

// File: doc/picorv32_freeahb_bridge.md
Name: picorv32_freeahb_bridge

Overview:
Second-generation bridge from the PicoRV32 native memory interface to the FreeAHB master user interface. Each write-strobe pattern is split into the minimum number of naturally aligned AHB transfers (word, halfword, byte), with data placed on the correct byte lanes for either endianness. Read data is registered, and bus-side aborts are handled cleanly. An optional watchdog prevents a stalled slave from hanging the CPU. The block sits between picorv32 and the FreeAHB master inside the GRLIB AHB wrapper.

Parameters:
BIG_ENDIAN_AHB, 1, 1: byte offset 0 maps to lanes [31:24]; 0: byte offset 0 maps to lanes [7:0].
MERGE_STROBES, 1, 1: merge aligned strobe runs into halfword/word transfers; 0: every set strobe becomes one byte transfer.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; must be >=2. Used only with the optional feature.
ERR_RDATA, 32'hDEADBEEF, value returned on a timed-out read.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
mem_valid  in  1  PicoRV32 request valid
mem_instr  in  1  instruction fetch
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  32  byte address
mem_wdata  in  32  write data, little-endian lanes
mem_wstrb  in  4  byte strobes; 0 = read
mem_rdata  out  32  registered read data, little-endian lanes
freeahb_wdata  out  32  write data on AHB lanes
freeahb_valid  out  1  write data valid (data phase)
freeahb_addr  out  32  transfer address
freeahb_size  out  3  000 byte, 001 halfword, 010 word
freeahb_write  out  1  write request
freeahb_read  out  1  read request
freeahb_min_len  out  32  constant 0
freeahb_cont  out  1  constant 0
freeahb_prot  out  4  0000 fetch, 0001 data
freeahb_lock  out  1  constant 0
freeahb_next  in  1  phase accepted
freeahb_rdata  in  32  read data
freeahb_result_addr  in  32  unused
freeahb_ready  in  1  freeahb_rdata valid
bus_timeout  out  1  one-cycle pulse on watchdog expiry (tied 0 when the feature is compiled out)

Behaviour:
- Reset (async): all outputs 0; state IDLE; byte pointer ptr=0.
- States: IDLE, RD_ADDR, RD_DATA, WR_PLAN, WR_ADDR, WR_DATA, DONE.
- IDLE: on mem_valid && !mem_ready:
  - wstrb==0 goes to RD_ADDR, with addr = {mem_addr[31:2],2'b00}, size=010, read=1.
  - Otherwise goes to WR_PLAN with ptr=0.
  - prot is latched from mem_instr.
- RD_ADDR: hold read/addr until freeahb_next, then read=0 and go to RD_DATA.
- RD_DATA: on freeahb_ready, capture freeahb_rdata into mem_rdata (byte-reversed if BIG_ENDIAN_AHB), then go to DONE.
- WR_PLAN: one cycle per step.
  - ptr==4: go to DONE.
  - MERGE_STROBES && ptr==0 && wstrb==1111: word at offset 0, ptr+=4.
  - MERGE_STROBES && ptr even && wstrb[ptr+1:ptr]==11: halfword, ptr+=2.
  - wstrb[ptr]: byte, ptr+=1.
  - Otherwise skip, ptr+=1, stay in WR_PLAN.
  - When a transfer is issued: addr = {mem_addr[31:2],ptr[1:0]}, size set, write=1, go to WR_ADDR.
- WR_ADDR: on freeahb_next, drive freeahb_wdata and set valid=1, then go to WR_DATA.
  - Lanes covered by the transfer carry the corresponding mem_wdata bytes. Offset k maps to lanes [31-8k:24-8k] when big-endian, [8k+7:8k] otherwise.
  - Other lanes are 0.
- WR_DATA: on freeahb_next, set write=0 and valid=0, then go to WR_PLAN.
- DONE: mem_ready=1 for exactly one cycle, then IDLE. IDLE ignores mem_valid during the mem_ready cycle.
- mem_rdata holds its value until the next read completes.
- mem_valid deasserted while in RD_ADDR/WR_ADDR before freeahb_next: drop the request and return to IDLE without mem_ready.
- mem_valid deasserted after the address phase is accepted: finish the bus transfer and suppress mem_ready.
- freeahb_next and freeahb_ready in the same RD_ADDR cycle: treat as next only. RD_DATA waits for ready.

Optional Feature:
- Macro PICORV32_FREEAHB_TIMEOUT_EN.
- Defined:
  - A counter clears on every state change and increments in RD_ADDR, RD_DATA, WR_ADDR and WR_DATA.
  - When it reaches TIMEOUT_CYCLES-1: deassert read/write/valid, pulse bus_timeout, go to DONE.
  - A read also loads ERR_RDATA into mem_rdata.
  - A write abandons any remaining strobes.
- Undefined: no counter; bus_timeout constant 0; the bridge waits indefinitely.

Test Plan:
- Read at 0x100, slave returns 0x11223344, BIG_ENDIAN_AHB=1 -> addr 0x100, size 010; mem_rdata=0x44332211; one mem_ready pulse.
- Write wstrb=1111 at 0x200, wdata=0xAABBCCDD, MERGE_STROBES=1, big-endian -> one word transfer; freeahb_wdata=0xDDCCBBAA.
- wstrb=1101 at 0x300, wdata=0x11223344 -> byte @0x300 with lanes [31:24]=0x44, then halfword @0x302 with lanes [15:0]=0x2211; then mem_ready.
- wstrb=0101, MERGE_STROBES=0, little-endian -> bytes @0x300 ([7:0]=0x44) and @0x302 ([23:16]=0x22); exactly 2 write transfers.
- Reset asserted in WR_DATA -> all outputs 0 immediately; next request starts cleanly from IDLE.
- With PICORV32_FREEAHB_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with freeahb_next never asserted -> bus_timeout pulse at cycle 8; mem_rdata=0xDEADBEEF; mem_ready pulse.
